// File: rtl/cf_fft_pair_feeder_pkg.sv
// Shared constants for the FFT input feeder.
// Sample packing, twiddle ROM geometry and index helper.
package cf_fft_pkg;

  localparam int RE_MSB = 15;
  localparam int RE_LSB = 8;
  localparam int IM_MSB = 7;
  localparam int IM_LSB = 0;

  localparam int TW_ENTRIES = 64;
  localparam int TWW        = 6;

  // Left shift turning pair index k into a twiddle ROM address.
  function automatic int tw_shift(input int d);
    return $clog2(TW_ENTRIES / d);
  endfunction

endpackage

// File: rtl/cf_fft_pair_feeder_if.sv
// Stream bundle between the sample source and the butterfly.
// master drives samples; slave is the pair feeder.
interface cf_fft_pair_feeder_if #(
  parameter int DW  = 16,
  parameter int TWW = 6
);

  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_sof;
  logic [DW-1:0]  out_a;
  logic [DW-1:0]  out_b;
  logic [TWW-1:0] out_tw;
  logic           out_valid;
  logic           out_last;
  logic           err;

  modport master (
    output in_data,
    output in_valid,
    output in_sof,
    input  out_a,
    input  out_b,
    input  out_tw,
    input  out_valid,
    input  out_last,
    input  err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sof,
    output out_a,
    output out_b,
    output out_tw,
    output out_valid,
    output out_last,
    output err
  );

endinterface

// File: rtl/cf_fft_pair_feeder_delay_line.sv
// D-deep first-half buffer with synchronous write.
// The registered read port is the butterfly A stage.
module cf_fft_delay_line
  import cf_fft_pkg::*;
#(
  parameter int DW = 16,
  parameter int D  = 64,
  parameter int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clock_c,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [D];
  logic [DW-1:0] rd_q;

  // Store first-half samples; contents need no reset.
  always_ff @(posedge clock_c) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value between pairs.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/cf_fft_pair_feeder.sv
// Radix-2 pair feeder: buffers x[k], emits (x[k], x[k+D], tw).
// Optional framing check: FFT_FEEDER_FRAME_CHECK_EN.
module cf_fft_pair_feeder
  import cf_fft_pkg::*;
#(
  parameter int DW  = 16,
  parameter int D   = 64,
  parameter int TWW = 6
) (
  input  logic                 clock_c,
  input  logic                 reset,
  cf_fft_pair_feeder_if.slave  bus
);

  localparam int CW = $clog2(2 * D);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int SH = tw_shift(D);
  localparam logic [CW-1:0] KMASK = CW'(D - 1);
  localparam logic [AW-1:0] KLAST = AW'(D - 1);

  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [CW-1:0]  idx;
  logic           acc;
  logic           sof;
  logic           second;
  logic           pair;
  logic [AW-1:0]  k;
  logic [TWW-1:0] tw_n;
  logic           last_n;

  logic [DW-1:0]  b_q;
  logic [TWW-1:0] tw_q;
  logic           valid_q;
  logic           last_q;

  assign acc    = bus.in_valid;
  assign sof    = bus.in_valid & bus.in_sof;
  assign idx    = sof ? '0 : cnt;
  assign second = idx[CW-1];
  assign pair   = acc & second;
  assign k      = AW'(idx & KMASK);
  assign tw_n   = TWW'(k) << SH;
  assign last_n = (k == KLAST);

  // Next block position; 2D is a power of two so +1 wraps.
  always_comb begin
    cnt_n = cnt;
    unique case (1'b1)
      sof:        cnt_n = CW'(1);
      acc & ~sof: cnt_n = cnt + CW'(1);
      ~acc:       cnt_n = cnt;
      default:    cnt_n = cnt;
    endcase
  end

  // Block position register.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end

  cf_fft_delay_line #(
    .DW (DW),
    .D  (D),
    .AW (AW)
  ) u_dl (
    .clock_c (clock_c),
    .reset   (reset),
    .wr_en   (acc & ~second),
    .wr_addr (k),
    .wr_data (bus.in_data),
    .rd_en   (pair),
    .rd_addr (k),
    .rd_data (bus.out_a)
  );

  // Pair outputs; B and twiddle hold between pulses.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      b_q     <= '0;
      tw_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= pair;
      last_q  <= pair & last_n;
      if (pair) begin
        b_q  <= bus.in_data;
        tw_q <= tw_n;
      end
    end
  end

  assign bus.out_b     = b_q;
  assign bus.out_tw    = tw_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

`ifdef FFT_FEEDER_FRAME_CHECK_EN
  logic wrap_q;
  logic err_q;
  logic early;
  logic missing;

  assign early   = sof & (cnt != '0);
  assign missing = acc & ~bus.in_sof & wrap_q;

  // Remember a natural wrap until the next accepted sample.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else if (acc) begin
      wrap_q <= ~sof & (cnt == '1);
    end
  end

  // Sticky framing error.
  always_ff @(posedge clock_c) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (early | missing) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_cf_fft_pair_feeder.sv
// Scoreboard bench for cf_fft_pair_feeder at D=4 and D=64.
// Reference model keeps block buffers as plain arrays.
module tb_cf_fft_pair_feeder;

`ifdef FFT_FEEDER_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  tw;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] mem [2][64];
  int          pos [2];
  bit          wrapped [2];
  bit          errm [2];
  logic [15:0] ha [2];
  logic [15:0] hb [2];
  logic [5:0]  ht [2];

  cf_fft_pair_feeder_if #(.DW(16), .TWW(6)) bus0 ();
  cf_fft_pair_feeder_if #(.DW(16), .TWW(6)) bus1 ();

  cf_fft_pair_feeder #(.DW(16), .D(4), .TWW(6)) u0 (
    .clock_c (clk),
    .reset   (rst),
    .bus     (bus0)
  );

  cf_fft_pair_feeder #(.DW(16), .D(64), .TWW(6)) u1 (
    .clock_c (clk),
    .reset   (rst),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string nm,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %h exp %h",
               nm, id, cyc, got, exp);
    end
  endtask

  task automatic mon(input int id, input logic r, input logic v,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [5:0] tw, input logic l);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (r) begin
      chk(id, "rst_valid", v, 0);
      chk(id, "rst_a", a, 0);
      chk(id, "rst_b", b, 0);
      chk(id, "rst_tw", tw, 0);
      chk(id, "rst_last", l, 0);
      ha[id] = '0;
      hb[id] = '0;
      ht[id] = '0;
      if (id == 0) q0.delete();
      else q1.delete();
      return;
    end
    if (id == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
    end
    chk(id, "out_valid", v, have);
    if (have) begin
      chk(id, "out_a", a, e.a);
      chk(id, "out_b", b, e.b);
      chk(id, "out_tw", tw, e.tw);
      chk(id, "out_last", l, e.l);
      ha[id] = e.a;
      hb[id] = e.b;
      ht[id] = e.tw;
    end else if (!v) begin
      chk(id, "hold_a", a, ha[id]);
      chk(id, "hold_b", b, hb[id]);
      chk(id, "hold_tw", tw, ht[id]);
      chk(id, "idle_last", l, 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, rst, bus0.out_valid, bus0.out_a, bus0.out_b,
        bus0.out_tw, bus0.out_last);
    mon(1, rst, bus1.out_valid, bus1.out_a, bus1.out_b,
        bus1.out_tw, bus1.out_last);
  end

  // Reference: block position, first-half buffer, framing rules.
  task automatic accept(input int id, input logic [15:0] d, input bit s);
    int   dd;
    int   idx;
    exp_t e;
    dd = (id == 0) ? 4 : 64;
    idx = s ? 0 : pos[id];
    if (FC) begin
      if (s && pos[id] != 0) errm[id] = 1'b1;
      if (!s && wrapped[id]) errm[id] = 1'b1;
    end
    wrapped[id] = (idx == 2 * dd - 1);
    pos[id] = (idx + 1) % (2 * dd);
    if (idx < dd) begin
      mem[id][idx] = d;
    end else begin
      e.due = cyc + 1;
      e.a   = mem[id][idx - dd];
      e.b   = d;
      e.tw  = 6'((idx - dd) * (64 / dd));
      e.l   = (idx - dd == dd - 1);
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0;
    bus0.in_sof   = 1'b0;
    bus0.in_data  = 16'($urandom);
    bus1.in_valid = 1'b0;
    bus1.in_sof   = 1'b0;
    bus1.in_data  = 16'($urandom);
  endtask

  task automatic step(input int id, input bit v, input bit s,
                      input logic [15:0] d);
    @(negedge clk);
    chk(0, "err", bus0.err, errm[0]);
    chk(1, "err", bus1.err, errm[1]);
    idle();
    if (id == 0) begin
      bus0.in_valid = v;
      bus0.in_sof   = s;
      bus0.in_data  = d;
    end else begin
      bus1.in_valid = v;
      bus1.in_sof   = s;
      bus1.in_data  = d;
    end
    if (v) accept(id, d, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0;
      wrapped[i] = 1'b0;
      errm[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic block4(input int first, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b1, i == 0, 16'((first + i) * 16'h0101));
      if (gaps) step(0, 1'b0, 1'b0, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc %0d got running exp finished", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0;
      wrapped[i] = 1'b0;
      errm[i] = 1'b0;
      ha[i] = '0;
      hb[i] = '0;
      ht[i] = '0;
    end
    idle();
    do_reset();

    block4(1, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0, 16'h0);

    block4(1, 1'b1);
    repeat (3) step(0, 1'b0, 1'b0, 16'h0);

    block4(1, 1'b0);
    block4(9, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 6; i++)
      step(0, 1'b1, i == 0, 16'((i + 1) * 16'h0101));
    do_reset();
    block4(17, 1'b0);
    repeat (3) step(0, 1'b0, 1'b0, 16'h0);

    step(0, 1'b1, 1'b1, 16'h0101);
    step(0, 1'b1, 1'b0, 16'h0202);
    step(0, 1'b1, 1'b1, 16'h0303);
    repeat (4) step(0, 1'b0, 1'b0, 16'h0);
    do_reset();

    for (int i = 0; i < 128; i++)
      step(1, 1'b1, i == 0, 16'($urandom));
    repeat (3) step(1, 1'b0, 1'b0, 16'h0);

    for (int id = 0; id < 2; id++) begin
      do_reset();
      for (int n = 0; n < 400; n++) begin
        bit v;
        bit s;
        v = ($urandom % 4) != 0;
        if (pos[id] == 0) s = v && ($urandom % 4 != 0);
        else s = v && ($urandom % 40 == 0);
        step(id, v, s, 16'($urandom));
      end
      repeat (3) step(id, 1'b0, 1'b0, 16'h0);
    end

    chk(0, "drain", q0.size(), 0);
    chk(1, "drain", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
